prog_loader: RTL and testbench

// - Byte-stream program writer for the 14-bit instruction memory; it is the write side of the opcode path that pcounter/inst_reg read.
// - Decodes a small command stream (set address, write word, run, halt) and produces single-cycle program-memory write strobes.
// - Holds the core in reset (core_hold) while a program is being loaded. Sits between the host link and the writable program memory.

---
 rtl/prog_loader.sv | 141 ++++++++++++++
 tb/tb_prog_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream command decoder that writes 14-bit words into program memory
// and holds the core in reset while a program is loaded.
// Optional feature macro: PROG_LOADER_CSUM_EN adds an 8-bit running checksum of written
// bytes and a VERIFY (0x05) command that can block RUN on mismatch.
module prog_loader #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 14,
    parameter int MEM_DEPTH = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              core_hold,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, A_HI, A_LO, D_HI, D_LO, WR, V_B} state_t;
    localparam logic [7:0] CMD_SETADDR = 8'h01;
    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_RUN     = 8'h03;
    localparam logic [7:0] CMD_HALT    = 8'h04;
    localparam logic [7:0] CMD_VERIFY  = 8'h05;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        a_hi;
    logic [5:0]        d_hi;
    logic              accept;
    logic [15:0]       addr_full;
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] ptr_next;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]        hi_raw;
    logic [7:0]        sum;
    logic              csum_bad;
`endif
    // Byte handshake, assembled address/word and wrapping pointer increment
    always_comb begin
        accept    = in_valid & in_ready;
        addr_full = {a_hi, in_data};
        word      = DATA_W'({d_hi, in_data});
        ptr_next  = (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
    end
    // Command FSM with registered outputs; WR is the single write-strobe cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            a_hi      <= '0;
            d_hi      <= '0;
            in_ready  <= 1'b1;
            pm_we     <= 1'b0;
            pm_addr   <= '0;
            pm_wdata  <= '0;
            core_hold <= 1'b1;
            err       <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            hi_raw    <= '0;
            sum       <= '0;
            csum_bad  <= 1'b0;
`endif
        end else begin
            pm_we    <= 1'b0;
            in_ready <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    case (in_data)
                        CMD_SETADDR: state <= A_HI;
                        CMD_WRITE:   state <= D_HI;
`ifdef PROG_LOADER_CSUM_EN
                        CMD_RUN:     if (!csum_bad) core_hold <= 1'b0;
                        CMD_HALT: begin
                            core_hold <= 1'b1;
                            err       <= 1'b0;
                            sum       <= '0;
                            csum_bad  <= 1'b0;
                        end
                        CMD_VERIFY:  state <= V_B;
`else
                        CMD_RUN:     core_hold <= 1'b0;
                        CMD_HALT: begin
                            core_hold <= 1'b1;
                            err       <= 1'b0;
                        end
`endif
                        default:     err <= 1'b1;
                    endcase
                end
                A_HI: if (accept) begin
                    a_hi  <= in_data;
                    state <= A_LO;
                end
                A_LO: if (accept) begin
                    state <= IDLE;
                    if (32'(addr_full) >= MEM_DEPTH) err <= 1'b1;
                    else ptr <= addr_full[ADDR_W-1:0];
                end
                D_HI: if (accept) begin
                    d_hi  <= in_data[5:0];
`ifdef PROG_LOADER_CSUM_EN
                    hi_raw <= in_data;
`endif
                    state <= D_LO;
                end
                D_LO: if (accept) begin
                    if (core_hold) begin
                        state    <= WR;
                        pm_we    <= 1'b1;
                        pm_addr  <= ptr;
                        pm_wdata <= word;
                        in_ready <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
                        sum      <= sum + hi_raw + in_data;
`endif
                    end else begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end
                end
                WR: begin
                    state <= IDLE;
                    ptr   <= ptr_next;
                end
`ifdef PROG_LOADER_CSUM_EN
                V_B: if (accept) begin
                    state <= IDLE;
                    if (in_data != sum) begin
                        err      <= 1'b1;
                        csum_bad <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed command stream with a write scoreboard checked by a monitor
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'hA5;
    logic        in_ready;
    logic        pm_we;
    logic [10:0] pm_addr;
    logic [13:0] pm_wdata;
    logic        core_hold;
    logic        err;
    int          checks = 0;
    int          errors = 0;
    typedef struct packed {
        logic [10:0] a;
        logic [13:0] d;
    } wr_t;
    wr_t sb[$];

    prog_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .core_hold(core_hold), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte %0h never accepted", b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send(b0);
        send(b1);
        send(b2);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h5A;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic expect_wr(input logic [10:0] a, input logic [13:0] d);
        sb.push_back({a, d});
    endtask

    // Monitor: every write strobe must match the oldest expected write
    initial begin
        wr_t e;
        logic prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && pm_we) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, required no write", pm_addr, pm_wdata);
                end else begin
                    e = sb.pop_front();
                    if (pm_addr !== e.a || pm_wdata !== e.d) begin
                        errors++;
                        $display("FAIL write: addr %0h data %0h, required addr %0h data %0h", pm_addr, pm_wdata, e.a, e.d);
                    end
                end
                chk("ready_low_in_write", {31'b0, in_ready}, 32'd0);
                chk("we_single_cycle", {31'b0, prev_we}, 32'd0);
            end
            prev_we = pm_we;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(5);
        chk("rst_core_hold", {31'b0, core_hold}, 32'd1);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_pm_we", {31'b0, pm_we}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_pm_addr", {21'b0, pm_addr}, 32'd0);
        chk("rst_pm_wdata", {18'b0, pm_wdata}, 32'd0);

        expect_wr(11'h010, 14'h3FFF);
        expect_wr(11'h011, 14'h002A);
        send3(8'h01, 8'h00, 8'h10);
        send3(8'h02, 8'h3F, 8'hFF);
        send3(8'h02, 8'h00, 8'h2A);
        idle(3);
        chk("basic_err", {31'b0, err}, 32'd0);

        expect_wr(11'h7FF, 14'h0001);
        expect_wr(11'h000, 14'h0001);
        expect_wr(11'h001, 14'h0005);
        send3(8'h01, 8'h07, 8'hFF);
        send3(8'h02, 8'h00, 8'h01);
        send3(8'h02, 8'h00, 8'h01);
        send3(8'h02, 8'hC0, 8'h05);
        idle(3);
        chk("wrap_err", {31'b0, err}, 32'd0);

        send(8'h07);
        idle(2);
        chk("illegal_cmd_err", {31'b0, err}, 32'd1);
        send(8'h04);
        idle(2);
        chk("halt_clears_err", {31'b0, err}, 32'd0);
        send3(8'h01, 8'h08, 8'h00);
        idle(2);
        chk("bad_addr_err", {31'b0, err}, 32'd1);
        send(8'h04);
        send(8'h03);
        idle(2);
        chk("run_core_hold", {31'b0, core_hold}, 32'd0);
        chk("run_err", {31'b0, err}, 32'd0);
        send3(8'h02, 8'h00, 8'h01);
        idle(3);
        chk("write_running_err", {31'b0, err}, 32'd1);
        send(8'h04);
        idle(2);
        chk("halt_err", {31'b0, err}, 32'd0);
        chk("halt_core_hold", {31'b0, core_hold}, 32'd1);
        expect_wr(11'h002, 14'h1234);
        send3(8'h02, 8'h12, 8'h34);
        idle(3);
`ifndef PROG_LOADER_CSUM_EN
        send(8'h05);
        idle(2);
        chk("verify_illegal_err", {31'b0, err}, 32'd1);
        send(8'h04);
`endif

        send3(8'h01, 8'h00, 8'h40);
        send(8'h02);
        send(8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        chk("midrst_core_hold", {31'b0, core_hold}, 32'd1);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_err", {31'b0, err}, 32'd0);
        expect_wr(11'h000, 14'h0005);
        send3(8'h02, 8'h00, 8'h05);
        idle(3);

`ifdef PROG_LOADER_CSUM_EN
        send(8'h04);
        expect_wr(11'h001, 14'h0102);
        send3(8'h02, 8'h01, 8'h02);
        send(8'h05);
        send(8'h03);
        send(8'h03);
        idle(2);
        chk("csum_ok_err", {31'b0, err}, 32'd0);
        chk("csum_ok_core_hold", {31'b0, core_hold}, 32'd0);
        send(8'h04);
        expect_wr(11'h002, 14'h0102);
        send3(8'h02, 8'h01, 8'h02);
        send(8'h05);
        send(8'h04);
        send(8'h03);
        idle(2);
        chk("csum_bad_err", {31'b0, err}, 32'd1);
        chk("csum_bad_core_hold", {31'b0, core_hold}, 32'd1);
`endif

        idle(5);
        chk("all_writes_seen", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
